// File: rtl/bexkat1_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// bexkat1_pipe_ctrl
//
// Hazard and sequencing controller for the bexkat1 five-stage pipeline
// (IF, ID, EX, MEM, WB). Each cycle it decides which stage registers hold
// their value and which load a NOP. It also tracks the squash window after a
// taken branch, the halt state, and a saturating count of front-end stall
// cycles.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   id_ir_i         instruction word in ID (type [31:28], ra [23:20],
//                   rb [19:16], rc [15:12])
//   ex_ir_i         instruction word in EX
//   ex_reg_write_i  EX register-write enable; nonzero means EX writes ra
//   ex_pc_set_i     registered taken branch/jump from EX (branch now in MEM)
//   ex_halt_i       registered halt from EX
//   ex_busy_i       multi-cycle integer unit busy in EX
//   mem_stall_i     data bus wait in MEM
//   stall_o         hold enables {mem,ex,id,if}; 1 = the register keeps its value
//   bubble_o        NOP inject {mem,ex,id}; 1 = the register loads a NOP
//   state_o         0 = RUN, 1 = FLUSH, 2 = HALT
//   stall_count_o   number of cycles with stall_o[0]=1 since reset
// ---------------------------------------------------------------------------
module bexkat1_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [63:0]          id_ir_i,
    input  logic [63:0]          ex_ir_i,
    input  logic [1:0]           ex_reg_write_i,
    input  logic                 ex_pc_set_i,
    input  logic                 ex_halt_i,
    input  logic                 ex_busy_i,
    input  logic                 mem_stall_i,
    output logic [3:0]           stall_o,
    output logic [2:0]           bubble_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_count_o
);

    // Instruction type code of a memory load.
    localparam logic [3:0] T_LOAD     = 4'h7;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Identifies which priority rule won this cycle; drives the state update.
    typedef enum logic [3:0] {
        R_RESET   = 4'd0,
        R_HALTED  = 4'd1,
        R_HALT    = 4'd2,
        R_MEM     = 4'd3,
        R_BRANCH  = 4'd4,
        R_BUSY    = 4'd5,
        R_LOADUSE = 4'd6,
        R_FLUSH   = 4'd7,
        R_IDLE    = 4'd8
    } rule_t;

    state_t                 state_r;
    logic [2:0]             flush_cnt_r;
    logic                   pend_flush_r;
    logic [CNT_WIDTH-1:0]   stall_count_r;

    rule_t                  rule_s;
    logic [3:0]             stall_s;
    logic [2:0]             bubble_s;
    logic                   load_use_s;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        load_use_s = 1'b0;
        if ((ex_ir_i[31:28] == T_LOAD) && (ex_reg_write_i != 2'd0) &&
            ((ex_ir_i[23:20] == id_ir_i[19:16]) ||
             (ex_ir_i[23:20] == id_ir_i[15:12]))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Priority resolution of stall/bubble controls; first matching rule wins.
    always_comb begin
        rule_s   = R_IDLE;
        stall_s  = 4'b0000;
        bubble_s = 3'b000;
        if (rst_i) begin
            rule_s   = R_RESET;
            stall_s  = 4'b0000;
            bubble_s = 3'b111;
        end else if (state_r == ST_HALT) begin
            rule_s   = R_HALTED;
            stall_s  = 4'b1111;
            bubble_s = 3'b000;
        end else if (ex_halt_i) begin
            rule_s   = R_HALT;
            stall_s  = 4'b1111;
            bubble_s = 3'b000;
        end else if (mem_stall_i) begin
            rule_s   = R_MEM;
            stall_s  = 4'b1111;
            bubble_s = 3'b000;
        end else if (ex_pc_set_i || pend_flush_r) begin
            // Squash IF-fetched and ID-decoded wrong-path instructions.
            rule_s   = R_BRANCH;
            stall_s  = 4'b0000;
            bubble_s = 3'b110;
        end else if (ex_busy_i) begin
            rule_s   = R_BUSY;
            stall_s  = 4'b0111;
            bubble_s = 3'b100;
        end else if (load_use_s) begin
            rule_s   = R_LOADUSE;
            stall_s  = 4'b0011;
            bubble_s = 3'b010;
        end else if (state_r == ST_FLUSH) begin
            rule_s   = R_FLUSH;
            stall_s  = 4'b0000;
            bubble_s = 3'b001;
        end else begin
            rule_s   = R_IDLE;
            stall_s  = 4'b0000;
            bubble_s = 3'b000;
        end
    end

    assign stall_o       = stall_s;
    assign bubble_o      = bubble_s;
    assign state_o       = state_r;
    assign stall_count_o = stall_count_r;

    // Sequencing state machine, pending-flush flag and stall-cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= ST_RUN;
            flush_cnt_r   <= 3'd0;
            pend_flush_r  <= 1'b0;
            stall_count_r <= '0;
        end else begin
            // Halt-entry cycle still counts; cycles spent in HALT do not.
            if (stall_s[0] && (state_r != ST_HALT) && (stall_count_r != '1)) begin
                stall_count_r <= stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stall_count_r <= stall_count_r;
            end

            case (rule_s)
                R_HALT: begin
                    state_r <= ST_HALT;
                end
                R_MEM: begin
                    // A branch arriving under a bus wait is remembered and
                    // acted on once MEM releases.
                    if (ex_pc_set_i) begin
                        pend_flush_r <= 1'b1;
                    end else begin
                        pend_flush_r <= pend_flush_r;
                    end
                end
                R_BRANCH: begin
                    pend_flush_r <= 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= FLUSH_INIT;
                    end else begin
                        state_r     <= ST_RUN;
                        flush_cnt_r <= 3'd0;
                    end
                end
                R_FLUSH: begin
                    flush_cnt_r <= flush_cnt_r - 3'd1;
                    if (flush_cnt_r <= 3'd1) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bexkat1_pipe_ctrl.sv
module tb_bexkat1_pipe_ctrl;

    localparam int FC  = 2;
    localparam int CW  = 32;
    localparam logic [3:0] T_LOAD = 4'h7;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [63:0]   id_ir_i, ex_ir_i;
    logic [1:0]    ex_reg_write_i;
    logic          ex_pc_set_i, ex_halt_i, ex_busy_i, mem_stall_i;
    logic [3:0]    stall_o;
    logic [2:0]    bubble_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_count_o;

    bexkat1_pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_ir_i(id_ir_i), .ex_ir_i(ex_ir_i),
        .ex_reg_write_i(ex_reg_write_i), .ex_pc_set_i(ex_pc_set_i),
        .ex_halt_i(ex_halt_i), .ex_busy_i(ex_busy_i), .mem_stall_i(mem_stall_i),
        .stall_o(stall_o), .bubble_o(bubble_o), .state_o(state_o),
        .stall_count_o(stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode name, cycles of squash still owed, pending branch.
    int          m_mode;     // 0 run, 1 flushing, 2 halted
    int          m_left;
    bit          m_pend;
    longint      m_cnt;
    bit          m_valid = 1'b0;
    longint      cnt_max = (64'd1 << CW) - 64'd1;
    logic [3:0]  e_stall;
    logic [2:0]  e_bubble;
    string       e_rule;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_ir(input logic [3:0] ty, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        logic [31:0] hi;
        logic [3:0]  mid;
        logic [11:0] lo;
        hi  = $urandom;
        mid = 4'($urandom);
        lo  = 12'($urandom);
        return {hi, ty, mid, ra, rb, rc, lo};
    endfunction

    task automatic idle_inputs();
        rst_i = 1'b0; id_ir_i = 64'd0; ex_ir_i = 64'd0; ex_reg_write_i = 2'd0;
        ex_pc_set_i = 1'b0; ex_halt_i = 1'b0; ex_busy_i = 1'b0; mem_stall_i = 1'b0;
    endtask

    // Wait until mid-cycle, derive expectations from the model and compare.
    task automatic settle();
        bit lu;
        #3;
        lu = (ex_ir_i[31:28] == T_LOAD) && (ex_reg_write_i != 2'd0) &&
             (ex_ir_i[23:20] == id_ir_i[19:16] || ex_ir_i[23:20] == id_ir_i[15:12]);
        if (rst_i)                      begin e_rule = "reset";  e_stall = 4'hF & 4'h0; e_bubble = 3'b111; end
        else if (m_mode == 2)           begin e_rule = "halted"; e_stall = 4'b1111; e_bubble = 3'b000; end
        else if (ex_halt_i)             begin e_rule = "halt";   e_stall = 4'b1111; e_bubble = 3'b000; end
        else if (mem_stall_i)           begin e_rule = "mem";    e_stall = 4'b1111; e_bubble = 3'b000; end
        else if (ex_pc_set_i || m_pend) begin e_rule = "branch"; e_stall = 4'b0000; e_bubble = 3'b110; end
        else if (ex_busy_i)             begin e_rule = "busy";   e_stall = 4'b0111; e_bubble = 3'b100; end
        else if (lu)                    begin e_rule = "lduse";  e_stall = 4'b0011; e_bubble = 3'b010; end
        else if (m_mode == 1)           begin e_rule = "flush";  e_stall = 4'b0000; e_bubble = 3'b001; end
        else                            begin e_rule = "idle";   e_stall = 4'b0000; e_bubble = 3'b000; end
        chk({"stall/", e_rule}, longint'(stall_o), longint'(e_stall));
        chk({"bubble/", e_rule}, longint'(bubble_o), longint'(e_bubble));
        if (m_valid) begin
            chk("state", longint'(state_o), longint'(m_mode));
            chk("stall_count", longint'(stall_count_o), m_cnt);
        end
    endtask

    // Apply the clock edge to the model, then move to just after the edge.
    task automatic advance();
        if (rst_i) begin
            m_mode = 0; m_left = 0; m_pend = 1'b0; m_cnt = 0; m_valid = 1'b1;
        end else begin
            if (e_stall[0] && m_mode != 2 && m_cnt < cnt_max) m_cnt++;
            if (e_rule == "halt") m_mode = 2;
            else if (e_rule == "mem") begin
                if (ex_pc_set_i) m_pend = 1'b1;
            end else if (e_rule == "branch") begin
                m_pend = 1'b0;
                if (FC > 1) begin m_mode = 1; m_left = FC - 1; end
            end else if (e_rule == "flush") begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    initial begin
        idle_inputs();
        @(posedge clk_i);
        #1;

        // Reset for three cycles, then idle.
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_stall", longint'(stall_o), 0);
            chk("rst_bubble", longint'(bubble_o), 7);
            advance();
        end
        rst_i = 1'b0;
        settle();
        chk("post_rst_state", longint'(state_o), 0);
        chk("post_rst_stall", longint'(stall_o), 0);
        chk("post_rst_bubble", longint'(bubble_o), 0);
        chk("post_rst_count", longint'(stall_count_o), 0);
        advance();

        // Single-cycle taken branch.
        ex_pc_set_i = 1'b1;
        settle();
        chk("br_c0_bubble", longint'(bubble_o), 6);
        chk("br_c0_stall", longint'(stall_o), 0);
        advance();
        ex_pc_set_i = 1'b0;
        settle();
        chk("br_c1_state", longint'(state_o), 1);
        chk("br_c1_bubble", longint'(bubble_o), 1);
        advance();
        settle();
        chk("br_c2_state", longint'(state_o), 0);
        chk("br_c2_bubble", longint'(bubble_o), 0);
        advance();

        // Load-use hazard, then a non-matching pair.
        ex_ir_i = mk_ir(T_LOAD, 4'd3, 4'd9, 4'd10);
        ex_reg_write_i = 2'd1;
        id_ir_i = mk_ir(4'h2, 4'd1, 4'd3, 4'd8);
        settle();
        chk("lu_stall", longint'(stall_o), 3);
        chk("lu_bubble", longint'(bubble_o), 2);
        advance();
        id_ir_i = mk_ir(4'h2, 4'd3, 4'd4, 4'd5);
        settle();
        chk("nolu_stall", longint'(stall_o), 0);
        chk("nolu_bubble", longint'(bubble_o), 0);
        advance();

        // Bus wait for three cycles with a branch arriving in the first.
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mem_stall_i = 1'b1;
        ex_pc_set_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mem_stall", longint'(stall_o), 15);
            advance();
            ex_pc_set_i = 1'b0;
        end
        mem_stall_i = 1'b0;
        settle();
        chk("mem_count", longint'(stall_count_o), 3);
        chk("mem_pend_bubble", longint'(bubble_o), 6);
        advance();
        settle();
        chk("mem_flush_bubble", longint'(bubble_o), 1);
        chk("mem_flush_state", longint'(state_o), 1);
        advance();
        settle();
        chk("mem_run_state", longint'(state_o), 0);
        advance();

        // Busy and load-use together, then busy drops.
        ex_ir_i = mk_ir(T_LOAD, 4'd6, 4'd0, 4'd0);
        ex_reg_write_i = 2'd2;
        id_ir_i = mk_ir(4'h3, 4'd0, 4'd1, 4'd6);
        ex_busy_i = 1'b1;
        settle();
        chk("busy_stall", longint'(stall_o), 7);
        chk("busy_bubble", longint'(bubble_o), 4);
        advance();
        ex_busy_i = 1'b0;
        settle();
        chk("after_busy_stall", longint'(stall_o), 3);
        chk("after_busy_bubble", longint'(bubble_o), 2);
        advance();

        // Halt: everything frozen until reset.
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        ex_halt_i = 1'b1;
        settle();
        chk("halt_stall", longint'(stall_o), 15);
        advance();
        ex_halt_i = 1'b0;
        mem_stall_i = 1'b1;
        ex_pc_set_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("halted_state", longint'(state_o), 2);
            chk("halted_stall", longint'(stall_o), 15);
            chk("halted_bubble", longint'(bubble_o), 0);
            chk("halted_count", longint'(stall_count_o), 1);
            advance();
        end
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        chk("unhalt_state", longint'(state_o), 0);
        advance();

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst_i          = (m_mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 79) == 0);
            ex_halt_i      = ($urandom_range(0, 99) == 0);
            mem_stall_i    = ($urandom_range(0, 4) == 0);
            ex_pc_set_i    = ($urandom_range(0, 5) == 0);
            ex_busy_i      = ($urandom_range(0, 5) == 0);
            ex_reg_write_i = 2'($urandom_range(0, 3));
            ex_ir_i = mk_ir(($urandom_range(0, 1) == 0) ? T_LOAD : 4'($urandom),
                            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            id_ir_i = mk_ir(4'($urandom), 4'($urandom_range(0, 3)),
                            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bexkat1_pipe_ctrl.md
Name: bexkat1_pipe_ctrl

Overview:
Central hazard and sequencing controller for the bexkat1 five-stage pipeline (IF, ID, EX, MEM, WB).
- Decides every cycle which stage registers hold (stall) and which load a NOP (bubble).
- Inputs: decode/execute instruction words, execute branch/halt flags, memory wait, multi-cycle EX busy.
- Tracks branch-flush refill and halt state; exports a stall-cycle performance counter.

Parameters:
FLUSH_CYCLES, 2, total cycles of squash after a taken branch/jump (range 1..7).
CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_ir_i  in  64  instruction in ID (fields: type [31:28], ra [23:20], rb [19:16], rc [15:12])
ex_ir_i  in  64  instruction in EX
ex_reg_write_i  in  2  EX register-write enable; nonzero = writes ra
ex_pc_set_i  in  1  registered taken branch/jump from execute (branch now in MEM)
ex_halt_i  in  1  registered halt from execute
ex_busy_i  in  1  multi-cycle integer unit busy in EX
mem_stall_i  in  1  data bus wait in MEM
stall_o  out  4  hold enables {mem,ex,id,if}; 1 = stage register keeps its value
bubble_o  out  3  NOP inject {mem,ex,id}; 1 = stage register loads ir=0, reg_write=0
state_o  out  2  0=RUN, 1=FLUSH, 2=HALT
stall_count_o  out  CNT_WIDTH  cycles with stall_o[0]=1 since reset

Behaviour:
- stall_o and bubble_o are combinational from inputs and registered state. state_o, flush counter, pending flag and stall_count_o are registered.
- Reset (sampled on clk_i):
  - While rst_i=1: stall_o=0, bubble_o=3'b111.
  - On reset exit: state=RUN, flush_cnt=0, pend_flush=0, stall_count_o=0.
- Evaluation priority per cycle, highest first; only the winning rule drives outputs:
  1. HALT state: stall_o=4'b1111, bubble_o=0. Leave HALT only via reset; all inputs ignored.
  2. ex_halt_i=1: stall_o=4'b1111, bubble_o=0; next state=HALT.
  3. mem_stall_i=1: stall_o=4'b1111, bubble_o=0.
     - If ex_pc_set_i=1, set pend_flush.
     - Flush counter does not decrement.
  4. ex_pc_set_i=1 or pend_flush=1 (branch taken): stall_o=0, bubble_o=3'b110.
     - Clear pend_flush.
     - If FLUSH_CYCLES>1: state=FLUSH, flush_cnt=FLUSH_CYCLES-1; else stay RUN.
     - A taken branch in FLUSH state restarts the count.
  5. ex_busy_i=1: stall_o=4'b0111, bubble_o=3'b100.
  6. Load-use: ex_ir_i type==T_LOAD, ex_reg_write_i!=0, and ex ra equals id rb or id rc.
     - stall_o=4'b0011, bubble_o=3'b010 for one cycle; re-evaluated each cycle.
  7. FLUSH state, none of the above: stall_o=0, bubble_o=3'b001.
     - Decrement flush_cnt; at 1->0 return to RUN.
     - Rules 5/6 preempt for that cycle; the counter holds.
  8. Otherwise: stall_o=0, bubble_o=0.
- stall_count_o:
  - Increments each cycle stall_o[0]=1 and state!=HALT.
  - Saturates at all-ones.
  - Cycles with rst_i=1 are not counted.
- Reset mid-FLUSH or mid-HALT: returns to RUN next cycle; pending flush discarded.
- No latency on stall/bubble: same-cycle response to inputs.

Test Plan:
- Reset 3 cycles, then idle inputs -> during reset bubble_o=111, stall_o=0; after: state_o=0, stall_o=0, bubble_o=0, stall_count_o=0.
- ex_pc_set_i pulse 1 cycle, FLUSH_CYCLES=2 -> cycle0: bubble_o=110, state->1; cycle1: bubble_o=001; cycle2: state_o=0, bubble_o=000.
- ex_ir_i=T_LOAD ra=3 with ex_reg_write_i=1, id_ir_i rb=3 -> stall_o=0011, bubble_o=010 that cycle; id rb=4, rc=5 -> no stall.
- mem_stall_i high 3 cycles with ex_pc_set_i asserted in first -> stall_o=1111 for 3 cycles, stall_count_o=3; 4th cycle bubble_o=110; then FLUSH one cycle.
- ex_busy_i and load-use hazard simultaneously -> stall_o=0111, bubble_o=100; after busy drops, load-use rule applies if still matching.
- ex_halt_i pulse -> stall_o=1111 thereafter, state_o=2, stall_count_o frozen; later mem_stall_i/ex_pc_set_i ignored; rst_i returns state_o=0.
